// File: rtl/seq_acc_pkg.sv
// Shared types and helpers for the frame accumulator.
package seq_acc_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ACC  = 1'b0;
  localparam state_t HOLD = 1'b1;

  // Sample counter width: max(1, clog2(len)).
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len <= 32'd1) ? 32'd1 : 32'($clog2(len));
  endfunction

endpackage

// File: rtl/seq_accumulator_adder.sv
// Team N-bit ripple-carry adder: sum = a + b + cin, carry-out on cout.
module n_bit_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  // Carry ripples bit by bit from cin to cout.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[N];

endmodule

// File: rtl/seq_accumulator.sv
// Frame accumulator: sums LEN samples per frame through the team adder and
// presents the frame total with a sticky carry-out flag on a valid/ready stream.
module seq_accumulator
  import seq_acc_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf
);

  localparam int unsigned CNT_W = cnt_width(LEN);

  state_t             state, state_nxt;
  logic [N-1:0]       acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic [N-1:0]       out_sum_nxt;
  logic               out_ovf_nxt;
  logic [N-1:0]       add_s;
  logic               add_c;
  logic               last_c;

  n_bit_adder #(.N(N)) u_add (
    .a    (acc),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

  assign in_ready = (state == ACC);
  assign last_c   = (cnt == CNT_W'(LEN - 1));

  // Next-state and datapath update; clr beats a same-cycle accept in ACC.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    out_sum_nxt = out_sum;
    out_ovf_nxt = out_ovf;
    case (state)
      ACC: begin
        if (clr) begin
          acc_nxt = '0;
          cnt_nxt = '0;
          ovf_nxt = 1'b0;
        end else if (in_valid) begin
          if (last_c) begin
            out_sum_nxt = add_s;
            out_ovf_nxt = ovf | add_c;
            acc_nxt     = '0;
            cnt_nxt     = '0;
            ovf_nxt     = 1'b0;
            state_nxt   = HOLD;
          end else begin
            acc_nxt = add_s;
            cnt_nxt = cnt + CNT_W'(1);
            ovf_nxt = ovf | add_c;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      out_sum   <= out_sum_nxt;
      out_ovf   <= out_ovf_nxt;
      out_valid <= (state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_seq_accumulator.sv
// Self-checking bench: LEN=4 and LEN=1 instances share stimulus and are
// compared every cycle against a frame-level integer model.
module tb_seq_accumulator;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_ovf;
  logic [7:0] a_out_sum;
  logic       b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0] b_out_sum;

  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 0;

  // Model: per instance, frame in progress tracked as true integer total.
  bit m_hold [2];
  int m_cnt  [2];
  int m_total[2];
  int m_sum  [2];
  bit m_ovf  [2];

  seq_accumulator #(.N(8), .LEN(4)) dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf)
  );

  seq_accumulator #(.N(8), .LEN(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic mupd(input int k, input int len);
    if (rst) begin
      m_hold[k] = 0; m_cnt[k] = 0; m_total[k] = 0; m_sum[k] = 0; m_ovf[k] = 0;
    end else if (!m_hold[k]) begin
      if (clr) begin
        m_cnt[k] = 0; m_total[k] = 0;
      end else if (in_valid) begin
        m_total[k] += int'(in_data);
        m_cnt[k]++;
        if (m_cnt[k] == len) begin
          m_sum[k]   = m_total[k] % 256;
          m_ovf[k]   = (m_total[k] >= 256);
          m_hold[k]  = 1;
          m_cnt[k]   = 0;
          m_total[k] = 0;
        end
      end
    end else if (out_ready) begin
      m_hold[k] = 0;
    end
  endtask

  // One clock: drive at low phase, check in_ready, clock, check outputs.
  task automatic step(input logic r, input logic c, input logic v,
                      input logic [7:0] d, input logic ordy);
    rst = r; clr = c; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    if (armed) begin
      chk("a_in_ready", 32'(a_in_ready), 32'(!m_hold[0]));
      chk("b_in_ready", 32'(b_in_ready), 32'(!m_hold[1]));
    end
    @(posedge clk);
    mupd(0, 4);
    mupd(1, 1);
    @(negedge clk);
    armed = 1;
    chk("a_out_valid", 32'(a_out_valid), 32'(m_hold[0]));
    chk("a_out_sum",   32'(a_out_sum),   32'(m_sum[0]));
    chk("a_out_ovf",   32'(a_out_ovf),   32'(m_ovf[0]));
    chk("b_out_valid", 32'(b_out_valid), 32'(m_hold[1]));
    chk("b_out_sum",   32'(b_out_sum),   32'(m_sum[1]));
    chk("b_out_ovf",   32'(b_out_ovf),   32'(m_ovf[1]));
  endtask

  task automatic idle();
    step(0, 0, 0, 8'd0, 1);
    step(0, 0, 0, 8'd0, 1);
  endtask

  task automatic frame4(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
    step(0, 0, 1, s0, 1);
    step(0, 0, 1, s1, 1);
    step(0, 0, 1, s2, 1);
    step(0, 0, 1, s3, 1);
  endtask

  initial begin
    rst = 1; clr = 0; in_valid = 0; in_data = '0; out_ready = 0;

    // Reset held two cycles with a sample offered.
    step(1, 0, 1, 8'd77, 0);
    step(1, 0, 1, 8'd77, 0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_sum",  32'(a_out_sum),  32'd0);
    idle();

    // Plain frame.
    frame4(8'd10, 8'd20, 8'd30, 8'd40);
    chk("p2_sum",      32'(a_out_sum),   32'd100);
    chk("p2_ovf",      32'(a_out_ovf),   32'd0);
    chk("p2_valid",    32'(a_out_valid), 32'd1);
    chk("p2_rdy_low",  32'(a_in_ready),  32'd0);
    step(0, 0, 0, 8'd0, 1);
    chk("p2_rdy_back", 32'(a_in_ready),  32'd1);

    // Wrap with sticky carry, then a clean frame.
    frame4(8'd200, 8'd100, 8'd0, 8'd0);
    chk("p3_sum", 32'(a_out_sum), 32'd44);
    chk("p3_ovf", 32'(a_out_ovf), 32'd1);
    step(0, 0, 0, 8'd0, 1);
    frame4(8'd1, 8'd1, 8'd1, 8'd1);
    chk("p3b_sum", 32'(a_out_sum), 32'd4);
    chk("p3b_ovf", 32'(a_out_ovf), 32'd0);
    step(0, 0, 0, 8'd0, 1);

    // Back-pressure: result stable, samples ignored.
    step(0, 0, 1, 8'd50, 1);
    step(0, 0, 1, 8'd60, 1);
    step(0, 0, 1, 8'd70, 1);
    step(0, 0, 1, 8'd80, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 8'($urandom), 0);
      chk("p4_hold_sum", 32'(a_out_sum), 32'd4);
      chk("p4_hold_ovf", 32'(a_out_ovf), 32'd1);
    end
    step(0, 0, 0, 8'd0, 1);
    frame4(8'd2, 8'd3, 8'd4, 8'd5);
    chk("p4_next_sum", 32'(a_out_sum), 32'd14);
    idle();

    // Abort: 5, 7 and the clr-cycle 9 are all discarded.
    step(0, 0, 1, 8'd5, 1);
    step(0, 0, 1, 8'd7, 1);
    step(0, 1, 1, 8'd9, 1);
    frame4(8'd1, 8'd2, 8'd3, 8'd4);
    chk("p5_sum", 32'(a_out_sum), 32'd10);
    chk("p5_ovf", 32'(a_out_ovf), 32'd0);
    idle();

    // LEN=1 instance: each accept is a frame.
    step(0, 0, 1, 8'd255, 0);
    chk("p6_sum0", 32'(b_out_sum),   32'd255);
    chk("p6_ovf0", 32'(b_out_ovf),   32'd0);
    chk("p6_vld0", 32'(b_out_valid), 32'd1);
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) step(0, 0, 0, 8'd0, 1);
    step(0, 0, 1, 8'd3, 0);
    chk("p6_sum1", 32'(b_out_sum), 32'd3);
    chk("p6_ovf1", 32'(b_out_ovf), 32'd0);
    idle();

    // Random traffic with occasional clr and rst.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    // Reset while holding a frame drops out_valid.
    frame4(8'd9, 8'd9, 8'd9, 8'd9);
    step(1, 0, 1, 8'd1, 0);
    chk("rst_hold_valid", 32'(a_out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_accumulator.md
Name: seq_accumulator

Overview:
Frame accumulator that sits directly upstream of the team's N-bit ripple-carry adder. It sequences a stream of N-bit samples into the adder operands, one sample per cycle. It feeds back the adder sum as the running total and presents a registered per-frame total with a sticky overflow flag. Input and output are valid/ready streams, so the block can sit between a sample source and a result consumer.

Parameters:
N, 8, sample and accumulator width in bits (N >= 2).
LEN, 4, samples per frame (LEN >= 1).
CNT_W, max(1, clog2(LEN)), sample counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
clr  input  1  synchronous frame abort; discards the partial frame.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block accepts in_data this cycle.
in_data  input  N  sample.
out_valid  output  1  out_sum/out_ovf hold a completed frame.
out_ready  input  1  consumer takes the frame this cycle.
out_sum  output  N  frame total modulo 2^N.
out_ovf  output  1  1 if any add in the frame produced carry-out.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high and takes priority over everything.
- Reset values:
  - state=ACC, acc=0, cnt=0, ovf=0.
  - out_valid=0, out_sum=0, out_ovf=0.
  - in_ready=1 from the first cycle after reset.
- Adder: the add stage is purely combinational: {c,s} = acc + in_data, N-bit operands, unsigned.
  - s is the low N bits of the sum; c is the carry-out.
  - No sign extension and no saturation.
- States: ACC and HOLD.
  - in_ready = (state==ACC), combinational from state only.
  - out_valid = (state==HOLD), registered.
- ACC, accepted sample (in_valid & in_ready):
  - acc<=s, ovf<=ovf|c, cnt<=cnt+1.
- ACC, last sample (cnt==LEN-1 on acceptance):
  - out_sum<=s, out_ovf<=ovf|c.
  - acc<=0, cnt<=0, ovf<=0, state<=HOLD.
  - Latency: out_valid rises the cycle after the LEN-th accept.
- ACC, no accept: all state holds.
- HOLD:
  - out_sum and out_ovf are stable while out_valid=1 and out_ready=0.
  - On out_ready: state<=ACC. The next accept is possible in the following cycle.
  - Throughput: one frame per LEN+1 cycles, best case.
- LEN=1: every accepted sample completes a frame, so out_sum=in_data and out_ovf=0.
- Wrap-around: cnt returns to 0 after each frame. acc wraps modulo 2^N, and the wrap is recorded only in ovf.
- clr in ACC:
  - acc, cnt, ovf are zeroed.
  - A sample accepted in the same cycle is discarded (clr wins).
  - in_ready stays 1.
- clr in HOLD: no effect; the completed frame is not discarded.
- rst mid-frame or in HOLD: returns to reset values next edge. A pending frame is lost and out_valid drops.
- in_data and in_valid are ignored while in_ready=0.
- Simultaneous in_valid and out_ready: cannot conflict, since the two states are exclusive.

Decomposition:
- Package seq_acc_pkg:
  - state enum {ACC, HOLD}.
  - CNT_W derivation function (max(1, clog2(LEN))).
- Sub-module: the add stage is the team's n_bit_adder (parameter N), instantiated once.
  - Only its cout and the low N bits of its sum are used.
  - The block wraps it; it is not reimplemented inline.
- Remaining logic (FSM, counter, output registers) is in seq_accumulator itself.

Test Plan:
1. rst high 2 cycles, then low -> in_ready=1, out_valid=0, out_sum=0, out_ovf=0. Also: rst while in_valid=1 -> nothing accumulated.
2. N=8, LEN=4, samples 10,20,30,40 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept, out_sum=100, out_ovf=0. in_ready=0 that cycle, =1 the next.
3. Samples 200,100,0,0 -> out_sum=44, out_ovf=1. Next frame 1,1,1,1 -> out_sum=4, out_ovf=0 (sticky flag cleared per frame).
4. Complete frame with out_ready=0 for 5 cycles and in_valid held high with changing data -> out_sum/out_ovf stable, no sample accepted. Release out_ready -> next frame starts cleanly.
5. Accept 5,7, then clr together with in_valid (data 9), then 1,2,3,4 -> out_sum=10 (5, 7 and 9 all discarded).
6. LEN=1, samples 255 then 3 with random in_valid gaps -> two frames: out_sum=255 then 3, out_ovf=0 both.
